// File: rtl/logic_sweep_checker.sv
// Sweeps all 16 input vectors of y = (a & b) | (c ^ d), checks y_in against a golden model
// and reports error count, first failing vector and pass. Optional: LOGIC_SWEEP_STOP_ON_ERR_EN.
module logic_sweep_checker #(
  parameter int SETTLE_CYC = 1,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_in,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       first_fail,
  output logic             fail_valid
);

  // state  | meaning
  // IDLE   | waiting for start, results held
  // SETTLE | stimulus applied, waiting SETTLE_CYC cycles for y_in
  // CHECK  | compare y_in with golden model, advance vector
  // DONE   | final result latch; done pulses on the following cycle

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t        state;
  logic [3:0]    vec;
  logic [CW-1:0] settle_cnt;
  logic          expected;
  logic          mismatch;
  logic          last_check;

  assign expected = (vec[3] & vec[2]) | (vec[1] ^ vec[0]);
  assign mismatch = (y_in != expected);
`ifdef LOGIC_SWEEP_STOP_ON_ERR_EN
  assign last_check = mismatch || (vec == 4'hF);
`else
  assign last_check = (vec == 4'hF);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      vec          <= 4'h0;
      settle_cnt   <= '0;
      {a, b, c, d} <= 4'h0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_cnt      <= '0;
      first_fail   <= 4'h0;
      fail_valid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            vec          <= 4'h0;
            {a, b, c, d} <= 4'h0;
            settle_cnt   <= '0;
            err_cnt      <= '0;
            fail_valid   <= 1'b0;
            first_fail   <= 4'h0;
            pass         <= 1'b0;
            busy         <= 1'b1;
            state        <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
            if (!fail_valid) begin
              first_fail <= vec;
              fail_valid <= 1'b1;
            end
          end
          if (last_check) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            vec          <= vec + 4'd1;
            {a, b, c, d} <= vec + 4'd1;
            settle_cnt   <= '0;
            state        <= S_SETTLE;
          end
        end
        S_DONE: begin
          // err_cnt already includes the final CHECK update here
          done  <= 1'b1;
          pass  <= (err_cnt == '0);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Directed self-checking bench for logic_sweep_checker: three instances cover default
// parameters, ERR_W=3 saturation and SETTLE_CYC=3.
module tb_logic_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1, start2;
  logic [1:0] mode0;

  logic a0, b0, c0, d0, busy0, done0, pass0, fv0;
  logic [7:0] err0;
  logic [3:0] ff0;
  logic a1, b1, c1, d1, busy1, done1, pass1, fv1;
  logic [2:0] err1;
  logic [3:0] ff1;
  logic a2, b2, c2, d2, busy2, done2, pass2, fv2;
  logic [7:0] err2;
  logic [3:0] ff2;
  logic y0, y1, y2;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  function automatic logic fmodel(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] ^ v[0]);
  endfunction

  // mode0: 0 correct, 1 stuck-0, 2 stuck-1, 3 inverted
  always_comb begin
    case (mode0)
      2'd0:    y0 = fmodel({a0, b0, c0, d0});
      2'd1:    y0 = 1'b0;
      2'd2:    y0 = 1'b1;
      default: y0 = ~fmodel({a0, b0, c0, d0});
    endcase
  end
  assign y1 = ~fmodel({a1, b1, c1, d1});
  assign y2 = fmodel({a2, b2, c2, d2});

  logic_sweep_checker u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .y_in(y0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .first_fail(ff0), .fail_valid(fv0));

  logic_sweep_checker #(.SETTLE_CYC(1), .ERR_W(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .y_in(y1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_fail(ff1), .fail_valid(fv1));

  logic_sweep_checker #(.SETTLE_CYC(3), .ERR_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .y_in(y2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .first_fail(ff2), .fail_valid(fv2));

  function automatic logic get_done(input int which);
    case (which)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Pulses start, counts posedges after the sampling edge until done is seen.
  // cyc = -1 if done never arrives within the budget.
  task automatic run(input int which, input int repulse_at, input bit chk_walk, output int cyc);
    logic [3:0] ev;
    @(negedge clk) set_start(which, 1'b1);
    @(posedge clk);
    @(negedge clk) set_start(which, 1'b0);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      set_start(which, (cyc == repulse_at));
      if (chk_walk && (cyc % 2 == 1) && cyc <= 31) begin
        ev = 4'((cyc - 1) / 2);
        compared++;
        if ({a0, b0, c0, d0} !== ev) begin
          mismatched++;
          $display("FAIL walk cyc=%0d abcd=%b expected=%b", cyc, {a0, b0, c0, d0}, ev);
        end
      end
      if (get_done(which)) break;
    end
    set_start(which, 1'b0);
    if (!get_done(which)) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({a0, b0, c0, d0, busy0, done0, pass0, fv0, ff0, err0} !== 20'h0) begin
      mismatched++;
      $display("FAIL reset_outputs got=%h expected=0",
               {a0, b0, c0, d0, busy0, done0, pass0, fv0, ff0, err0});
    end
    rst = 1'b0;
  endtask

  task automatic test_correct();
    int cyc;
    mode0 = 2'd0;
    run(0, -1, 1'b1, cyc);
    compared++;
    if (cyc !== 33) begin mismatched++; $display("FAIL correct_latency got=%0d expected=33", cyc); end
    compared++;
    if ({pass0, err0, fv0} !== {1'b1, 8'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL correct_result pass=%b err=%0d fv=%b expected pass=1 err=0 fv=0", pass0, err0, fv0);
    end
    @(negedge clk);
    compared++;
    if (done0 !== 1'b0) begin mismatched++; $display("FAIL done_width done=%b expected=0", done0); end
  endtask

  task automatic test_stuck0();
    int cyc;
    mode0 = 2'd1;
    run(0, -1, 1'b0, cyc);
`ifdef LOGIC_SWEEP_STOP_ON_ERR_EN
    compared++;
    if (cyc !== 5) begin mismatched++; $display("FAIL stop_latency got=%0d expected=5", cyc); end
    compared++;
    if ({pass0, err0, ff0, fv0} !== {1'b0, 8'd1, 4'b0001, 1'b1}) begin
      mismatched++;
      $display("FAIL stop_result pass=%b err=%0d ff=%b fv=%b expected 0/1/0001/1", pass0, err0, ff0, fv0);
    end
`else
    compared++;
    if (cyc !== 33) begin mismatched++; $display("FAIL stuck0_latency got=%0d expected=33", cyc); end
    compared++;
    if ({pass0, err0, ff0, fv0} !== {1'b0, 8'd10, 4'b0001, 1'b1}) begin
      mismatched++;
      $display("FAIL stuck0_result pass=%b err=%0d ff=%b fv=%b expected 0/10/0001/1", pass0, err0, ff0, fv0);
    end
`endif
  endtask

  task automatic test_stuck1_hold();
    int cyc;
    mode0 = 2'd2;
    run(0, -1, 1'b0, cyc);
`ifndef LOGIC_SWEEP_STOP_ON_ERR_EN
    compared++;
    if ({pass0, err0, ff0, fv0} !== {1'b0, 8'd6, 4'b0000, 1'b1}) begin
      mismatched++;
      $display("FAIL stuck1_result pass=%b err=%0d ff=%b fv=%b expected 0/6/0000/1", pass0, err0, ff0, fv0);
    end
`endif
    mode0 = 2'd0;
    repeat (6) @(negedge clk);
    compared++;
    if ({pass0, ff0, fv0, busy0} !== {1'b0, 4'b0000, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL result_hold pass=%b ff=%b fv=%b busy=%b expected 0/0000/1/0", pass0, ff0, fv0, busy0);
    end
  endtask

  task automatic test_saturate();
    int cyc;
    run(1, -1, 1'b0, cyc);
`ifdef LOGIC_SWEEP_STOP_ON_ERR_EN
    compared++;
    if ({pass1, err1, ff1} !== {1'b0, 3'd1, 4'b0000}) begin
      mismatched++;
      $display("FAIL sat_stop pass=%b err=%0d ff=%b expected 0/1/0000", pass1, err1, ff1);
    end
`else
    compared++;
    if (cyc !== 33) begin mismatched++; $display("FAIL sat_latency got=%0d expected=33", cyc); end
    compared++;
    if ({pass1, err1, ff1} !== {1'b0, 3'd7, 4'b0000}) begin
      mismatched++;
      $display("FAIL sat_result pass=%b err=%0d ff=%b expected 0/7/0000", pass1, err1, ff1);
    end
`endif
  endtask

  task automatic test_restart_ignored();
    int cyc;
    mode0 = 2'd0;
    run(0, 10, 1'b0, cyc);
    compared++;
    if (cyc !== 33) begin mismatched++; $display("FAIL restart_latency got=%0d expected=33", cyc); end
    compared++;
    if ({pass0, err0} !== {1'b1, 8'd0}) begin
      mismatched++;
      $display("FAIL restart_result pass=%b err=%0d expected 1/0", pass0, err0);
    end
  endtask

  task automatic test_settle3();
    int cyc;
    run(2, -1, 1'b0, cyc);
    compared++;
    if (cyc !== 65) begin mismatched++; $display("FAIL settle3_latency got=%0d expected=65", cyc); end
    compared++;
    if ({pass2, err2, fv2} !== {1'b1, 8'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL settle3_result pass=%b err=%0d fv=%b expected 1/0/0", pass2, err2, fv2);
    end
  endtask

  task automatic test_mid_reset();
    bit saw_done;
    mode0 = 2'd1;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    @(negedge clk) start0 = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    compared++;
    if ({a0, b0, c0, d0, busy0, done0, pass0, fv0, ff0, err0} !== 20'h0) begin
      mismatched++;
      $display("FAIL midrst_outputs got=%h expected=0",
               {a0, b0, c0, d0, busy0, done0, pass0, fv0, ff0, err0});
    end
    rst = 1'b0;
    start0 = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done0 || busy0) saw_done = 1'b1;
    end
    compared++;
    if (saw_done !== 1'b0) begin mismatched++; $display("FAIL midrst_activity got=1 expected=0"); end
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    mode0 = 2'd0;
    test_reset();
    test_correct();
    test_stuck0();
    test_stuck1_hold();
    test_saturate();
    test_restart_ignored();
    test_settle3();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/logic_sweep_checker.md
Name: logic_sweep_checker

Overview:
- Self-checking stimulus/response engine for the 4-input function y = (a & b) | (c ^ d).
- Sits on the driving side of that function: generates a, b, c, d and samples the returned y.
- Sweeps all 16 input vectors once per run, compares each y against an internal golden model, and reports error count, first failing vector and pass/fail.
- Intended as the on-chip exerciser for the combinational/nonblocking-assignment example logic.

Parameters:
- SETTLE_CYC, 1, cycles between updating a..d and sampling y_in; legal range >= 1.
- ERR_W, 8, width of error counter; counter saturates at 2^ERR_W-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  run request; sampled only in IDLE
- y_in  input  1  response of the function under test
- a  output  1  stimulus bit, vec[3]
- b  output  1  stimulus bit, vec[2]
- c  output  1  stimulus bit, vec[1]
- d  output  1  stimulus bit, vec[0]
- busy  output  1  high from cycle after start accepted until DONE
- done  output  1  one-cycle pulse at end of run
- pass  output  1  1 when err_cnt == 0; valid from done until next start
- err_cnt  output  ERR_W  mismatches this run, saturating
- first_fail  output  4  first mismatching vector {a,b,c,d}
- fail_valid  output  1  first_fail holds a captured vector

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state IDLE; a=b=c=d=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, fail_valid=0, vec=0, settle counter=0.
- Stimulus: a..d are registered straight from the 4-bit vec register; they change only on SETTLE entry.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 → vec<=0, settle_cnt<=0, err_cnt<=0, fail_valid<=0, first_fail<=0, pass<=0, go SETTLE.
  - start=0 → stay.
- SETTLE: busy=1; settle_cnt increments; at settle_cnt == SETTLE_CYC-1 go CHECK.
- CHECK:
  - Compute expected = (vec[3]&vec[2]) | (vec[1]^vec[0]).
  - On y_in != expected: err_cnt increments, saturating at 2^ERR_W-1. If fail_valid=0, first_fail<=vec and fail_valid<=1.
  - vec == 15 → go DONE.
  - Otherwise vec<=vec+1, settle_cnt<=0, go SETTLE.
- DONE: done=1 for exactly this cycle; busy=0; pass<=(err_cnt==0) including the final CHECK result; next cycle IDLE.
- Latency: done is asserted 16*(SETTLE_CYC+1)+1 cycles after the start-sampling edge; 33 cycles for SETTLE_CYC=1.
- start while busy or in DONE: ignored, no restart, no effect on results.
- Results (err_cnt, first_fail, fail_valid, pass) hold after DONE until the next accepted start.
- vec never wraps mid-run; 15 is terminal.
- rst mid-run: immediate return to reset values on that edge; no done pulse; partial results discarded.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro: LOGIC_SWEEP_STOP_ON_ERR_EN.
- Defined: the first mismatch in CHECK captures err_cnt=1 and first_fail, then goes directly to DONE without visiting remaining vectors; pass=0.
- Undefined: full 16-vector sweep always runs, as above.

Test Plan:
- Correct model on y_in, SETTLE_CYC=1: pulse start → done exactly 33 cycles later; pass=1, err_cnt=0, fail_valid=0; a..d walk 0000..1111.
- y_in stuck at 0 → err_cnt=10, first_fail=4'b0001, fail_valid=1, pass=0.
- y_in stuck at 1 → err_cnt=6, first_fail=4'b0000.
- Inverted model with ERR_W=3 → err_cnt saturates at 7 (true count 16); pass=0.
- Behaviour checks:
  - start re-pulsed at cycle 10 of a run → ignored, done still at cycle 33.
  - rst asserted at cycle 12 → next cycle all outputs 0, state IDLE, no done.
- SETTLE_CYC=3, correct model → done at cycle 65, pass=1.
- LOGIC_SWEEP_STOP_ON_ERR_EN defined, y_in stuck 0 → done at cycle 5, err_cnt=1, first_fail=4'b0001.
